alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter that shares the single combinational 32-bit ALU among `N_REQ` requesters (e.g. execute stage, branch-target adder, CSR/debug path). Each requester presents operands and a 4-bit ALU opcode over a valid/ready handshake. The block grants one requester per cycle, drives the shared ALU, and registers the result into a one-entry response slot tagged with the winner's index. It sits between the requesting pipeline units and the ALU instance.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand/result width.
- `ID_W`, default 2: width of requester index; must equal ceil(log2(N_REQ)).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester grant; one-hot or zero.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B, packed as `req_a`.
- `req_op`  in  N_REQ*4  opcode; requester i occupies bits [i*4 +: 4].
- `alu_a`, `alu_b`  out  WIDTH  operands to the shared ALU.
- `alu_op`  out  4  opcode to the shared ALU.
- `alu_out`  in  WIDTH  combinational ALU result.
- `rsp_valid`  out  1  response slot full.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  registered result.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_data`.
- `rsp_err`  out  1  the opcode was illegal (11..14).

## Operation
- Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRA, 9 SRL, 10 COPY_B, 15 NOP. Codes 11..14 are illegal.
- Slot state machine, two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on `rsp_ready` with no grant.
  - FULL -> FULL on `rsp_ready` with a grant (back-to-back).
  - FULL with `!rsp_ready`: hold; no grant; slot contents frozen.
- Grant permitted iff (EMPTY or `rsp_ready`) and any `req_valid`. Otherwise `req_ready`=0.
- Winner selection:
  - Round-robin pointer `ptr`. Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - The first index with `req_valid` set wins.
  - After a grant to index i, `ptr` <= (i+1) mod N_REQ. With no grant, `ptr` holds.
- `req_ready`:
  - Combinational. Only the winner's bit is set; the bit is computed from `req_valid`, `ptr` and slot state only.
  - `req_ready` never depends on `req_a`, `req_b` or `req_op`.
- ALU drive:
  - During a grant cycle: `alu_a`/`alu_b`/`alu_op` = the winner's fields.
  - Otherwise: 0/0/15, to suppress toggling.
- Capture on a grant:
  - `rsp_id` <= winner index.
  - Illegal opcode: `rsp_data` <= 0 and `rsp_err` <= 1.
  - Legal opcode: `rsp_data` <= `alu_out` and `rsp_err` <= 0.
- Requesters must hold `req_*` stable while valid and not ready. The arbiter does not check this.

## Timing
- Reset (async assert, release on clock edge):
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `ptr`=0.
  - `req_ready`=0 while `rst` is high.
  - ALU outputs = 0/0/15.
- Latency: a handshake (`req_valid` & `req_ready`) in cycle t gives `rsp_valid`=1 with its result in cycle t+1.
- Throughput: one op per cycle while `rsp_ready` is held high.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- Reset asserted mid-operation:
  - The slot is discarded immediately and asynchronously.
  - The in-flight response is lost; requesters must re-issue.
- Single requester active: it receives a grant every cycle that the slot permits; `ptr` still advances past it.
- Only the combinational path is ALU in -> slot register. No combinational path from `rsp_ready` to `rsp_data`.

## Test plan
- Reset:
  - Stimulus: assert `rst` with all `req_valid`=1.
  - Required: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `alu_op`=15.
  - After release, req0 is granted first.
- Single op:
  - Stimulus: req2 ADD with A=5, B=7; `rsp_ready`=1.
  - Required: `req_ready`=4'b0100 in cycle t; in cycle t+1, `rsp_valid`=1, `rsp_data`=12, `rsp_id`=2, `rsp_err`=0.
- Round-robin:
  - Stimulus: all four requesters valid continuously with `rsp_ready`=1.
  - Required: grant order 0,1,2,3,0,1; `rsp_id` follows the same order one cycle later.
- Backpressure:
  - Stimulus: slot full and `rsp_ready`=0 for 3 cycles, with req1 valid.
  - Required: `req_ready`=0 for those cycles; `rsp_data`/`rsp_id` unchanged.
  - On the cycle `rsp_ready` rises: req1 is granted in the same cycle, and its result appears next cycle.
- Illegal opcode:
  - Stimulus: req3 with op=12, A=1, B=1.
  - Required: `rsp_err`=1 and `rsp_data`=0, then the next legal op clears `rsp_err`.
- Async reset mid-stream:
  - Stimulus: pulse `rst` between clock edges while the slot is FULL.
  - Required: `rsp_valid` falls immediately, without waiting for an edge, and `ptr` returns to 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bundle between the requesting pipeline units,
// the shared ALU and the alu_arbiter.
interface alu_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*4-1:0]     req_op;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [3:0]             alu_op;
    logic [WIDTH-1:0]       alu_out;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_err;

    // Environment side: requesters, response consumer and the ALU itself.
    modport master (
        output req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters.
// The winner's operands drive the ALU in the grant cycle and the result is
// captured into a one-entry response slot tagged with the winner's index.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [WIDTH-1:0]   data;
    logic [ID_W-1:0]    id;
    logic               err;

    logic               found;
    logic [ID_W-1:0]    win;
    logic               slot_free;
    logic               grant;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [3:0]         sel_op;
    logic [N_REQ-1:0]   ready;

    // Opcodes 11..14 have no ALU meaning.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

    // Pointer moves one past the winner, wrapping at N_REQ (not a power of two in general).
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
        if (int'(i) == N_REQ - 1)
            return '0;
        else
            return i + ID_W'(1);
    endfunction

    // Winner search: indices ptr..N_REQ-1 first, then 0..ptr-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && (ID_W'(i) >= ptr) && bus.req_valid[ID_W'(i)]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && (ID_W'(i) < ptr) && bus.req_valid[ID_W'(i)]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    // Slot can take a new result when empty or when it drains this cycle.
    assign slot_free = (state == EMPTY) || bus.rsp_ready;
    assign grant     = slot_free && found && !rst;

    // Winner's operand mux; independent of the grant decision so req_ready never sees data.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a  = bus.req_a[i*WIDTH +: WIDTH];
                sel_b  = bus.req_b[i*WIDTH +: WIDTH];
                sel_op = bus.req_op[i*4 +: 4];
            end
        end
    end

    // One-hot grant to the winner, zero when no grant is possible.
    always_comb begin
        ready = '0;
        if (grant)
            ready[win] = 1'b1;
    end

    assign bus.req_ready = ready;

    // Idle ALU sees 0/0/NOP so its inputs do not toggle.
    assign bus.alu_a  = grant ? sel_a  : '0;
    assign bus.alu_b  = grant ? sel_b  : '0;
    assign bus.alu_op = grant ? sel_op : 4'hF;

    // Slot state machine, round-robin pointer and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= '0;
            data  <= '0;
            id    <= '0;
            err   <= 1'b0;
        end else begin
            if (grant) begin
                state <= FULL;
                ptr   <= next_ptr(win);
                id    <= win;
                if (is_illegal(sel_op)) begin
                    data <= '0;
                    err  <= 1'b1;
                end else begin
                    data <= bus.alu_out;
                    err  <= 1'b0;
                end
            end else if ((state == FULL) && bus.rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_data  = data;
    assign bus.rsp_id    = id;
    assign bus.rsp_err   = err;
endmodule
